// File: rtl/fp32_pkg.sv
// Shared single-precision float definitions: field widths, exponent limits,
// divider FSM states and field-extract helpers used by the NN datapath.
package fp32_pkg;

    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 254;
    localparam int EXP_W      = 8;
    localparam int MANT_W     = 23;
    localparam int QUOT_BITS  = 25;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM
    } div_state_e;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface fp_div_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    modport master (output start, a, b, input busy, done, result, div_by_zero);
    modport slave  (input start, a, b, output busy, done, result, div_by_zero);
endinterface

// File: rtl/fp_div_step.sv
// One restoring radix-2 division step: subtract the divisor if it fits,
// emit the quotient bit and shift the partial remainder left.
module fp_div_step
    import fp32_pkg::*;
(
    input  logic [QUOT_BITS-1:0] rem,
    input  logic [MANT_W:0]      mb,
    output logic [QUOT_BITS-1:0] rem_next,
    output logic                 qbit
);

    // The kept remainder is always below mb, so 24 bits hold it exactly.
    logic [MANT_W:0] diff;
    logic [MANT_W:0] kept;

    // Compare, conditionally subtract, shift.
    always_comb begin
        qbit     = (rem >= {1'b0, mb});
        diff     = rem[MANT_W:0] - mb;
        kept     = qbit ? diff : rem[MANT_W:0];
        rem_next = {kept, 1'b0};
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider (a / b). Fixed 26-edge latency
// from acceptance to done, truncating, denormals treated as zero.
module fp_div_seq
    import fp32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fp_div_seq_if.slave bus
);

    localparam logic [4:0] LAST_STEP = 5'(QUOT_BITS - 1);

    div_state_e           state;
    logic                 sign;
    logic [EXP_W-1:0]     ea;
    logic [EXP_W-1:0]     eb;
    logic [MANT_W:0]      mb;
    logic [QUOT_BITS-1:0] rem;
    logic [QUOT_BITS-1:0] q;
    logic [4:0]           cnt;
    logic                 busy_r;
    logic                 done_r;
    logic [31:0]          res_r;
    logic                 dbz_r;

    logic [QUOT_BITS-1:0] rem_next;
    logic                 qbit;
    logic signed [9:0]    exp_n;
    logic [MANT_W-1:0]    mant_n;
    logic [31:0]          res_n;
    logic                 dbz_n;

    fp_div_step u_step (
        .rem      (rem),
        .mb       (mb),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Normalise the quotient and resolve special cases (highest priority first).
    always_comb begin
        if (q[QUOT_BITS-1]) begin
            mant_n = q[MANT_W:1];
            exp_n  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(FP_BIAS));
        end else begin
            mant_n = q[MANT_W-1:0];
            exp_n  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(FP_BIAS - 1));
        end
        dbz_n = 1'b0;
        if (eb == '0) begin
            res_n = {sign, 8'hFF, 23'h0};
            dbz_n = 1'b1;
        end else if (ea == '0) begin
            res_n = {sign, 31'h0};
        end else if (exp_n > $signed(10'(FP_EXP_MAX))) begin
            res_n = {sign, 8'hFF, 23'h0};
        end else if (exp_n < 10'sd1) begin
            res_n = {sign, 31'h0};
        end else begin
            res_n = {sign, exp_n[EXP_W-1:0], mant_n};
        end
    end

    // Control FSM: accept in IDLE, iterate 25 steps, normalise and pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sign   <= 1'b0;
            ea     <= '0;
            eb     <= '0;
            mb     <= '0;
            rem    <= '0;
            q      <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            res_r  <= '0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign   <= fp_sign(bus.a) ^ fp_sign(bus.b);
                        ea     <= fp_exp(bus.a);
                        eb     <= fp_exp(bus.b);
                        mb     <= {1'b1, fp_mant(bus.b)};
                        rem    <= {2'b01, fp_mant(bus.a)};
                        q      <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem <= rem_next;
                    q   <= {q[QUOT_BITS-2:0], qbit};
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_STEP) state <= NORM;
                end
                NORM: begin
                    res_r  <= res_n;
                    dbz_r  <= dbz_n;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.result      = res_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: cycle model of the handshake plus a scoreboard of
// expected results, driven from a vector table and a few timing sequences.
module tb_fp_div_seq;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fp_div_seq_if bus();

    fp_div_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    cnt_m = 0;
    int    n_accept = 0;
    logic  done_m = 1'b0;
    logic  chk_en = 1'b0;
    logic [31:0] held_res = '0;
    logic  held_dbz = 1'b0;
    exp_t  cur_exp;
    exp_t  sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, want);
        end
    endtask

    // Independent reference: integer long division of the 1.m fractions.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic s;
        int ea, eb, e;
        longint unsigned ma, mb, q;
        logic [22:0] m;
        s = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        r.dbz = 1'b0;
        if (eb == 0) begin
            r.res = {s, 8'hFF, 23'h0};
            r.dbz = 1'b1;
        end else if (ea == 0) begin
            r.res = {s, 31'h0};
        end else begin
            ma = 64'h800000 | 64'(a[22:0]);
            mb = 64'h800000 | 64'(b[22:0]);
            q = (ma << 24) / mb;
            if (q >= 64'h1000000) begin
                m = q[23:1];
                e = ea - eb + 127;
            end else begin
                m = q[22:0];
                e = ea - eb + 126;
            end
            if (e > 254)    r.res = {s, 8'hFF, 23'h0};
            else if (e < 1) r.res = {s, 31'h0};
            else            r.res = {s, e[7:0], m};
        end
        return r;
    endfunction

    // Cycle model: acceptance, fixed latency, done timing, held result.
    always @(posedge clk) begin
        cyc++;
        done_m = 1'b0;
        if (rst) begin
            cnt_m = 0;
            held_res = '0;
            held_dbz = 1'b0;
            sb.delete();
        end else if (cnt_m > 0) begin
            cnt_m--;
            if (cnt_m == 0) begin
                done_m = 1'b1;
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    held_res = e.res;
                    held_dbz = e.dbz;
                end
            end
        end else if (bus.start) begin
            sb.push_back(cur_exp);
            cnt_m = 26;
            n_accept++;
        end
    end

    // Every cycle: outputs must match the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(cnt_m > 0));
            chk("done", 32'(bus.done), 32'(done_m));
            chk("result", bus.result, held_res);
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(held_dbz));
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cnt_m == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            bad++;
            total++;
            $display("FAIL idle_timeout cycle %0d: got busy want idle", cyc);
        end
    endtask

    task automatic wait_accepts(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_accept >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            bad++;
            total++;
            $display("FAIL accept_timeout cycle %0d: got %0d want %0d", cyc, n_accept, target);
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic ed);
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        cur_exp.res = er;
        cur_exp.dbz = ed;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        wait_idle();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
        vecs[2] = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0};
        vecs[3] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1};
        vecs[4] = '{32'h00000000, 32'h40A00000, 32'h00000000, 1'b0};
        vecs[5] = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[6] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0};
        vecs[7] = '{32'h00000000, 32'h00000000, 32'hFF800000 & 32'h7F800000, 1'b1};

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        cur_exp.res = '0;
        cur_exp.dbz = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table of directed vectors.
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz);

        // Random operands checked against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            exp_t e;
            ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            if (i % 4 == 3) rb[30:23] = 8'($urandom_range(0, 255));
            if (i % 5 == 4) ra[30:23] = 8'($urandom_range(0, 255));
            e = ref_div(ra, rb);
            run_op(ra, rb, e.res, e.dbz);
        end

        // Start held high: second op taken in the first done cycle.
        begin
            int n0;
            n0 = n_accept;
            @(negedge clk);
            bus.a = 32'h40C00000;
            bus.b = 32'h40000000;
            cur_exp.res = 32'h40400000;
            cur_exp.dbz = 1'b0;
            bus.start = 1'b1;
            wait_accepts(n0 + 1);
            bus.a = 32'h3F800000;
            bus.b = 32'h40400000;
            cur_exp.res = 32'h3EAAAAAA;
            cur_exp.dbz = 1'b0;
            wait_accepts(n0 + 2);
            bus.start = 1'b0;
            wait_idle();
        end

        // Start pulses during DIVIDE must be ignored.
        @(negedge clk);
        bus.a = 32'hC0F00000;
        bus.b = 32'h40200000;
        cur_exp.res = 32'hC0400000;
        cur_exp.dbz = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.a = 32'h3F800000;
        bus.b = 32'h00000000;
        cur_exp.res = 32'hDEADBEEF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Reset in the middle of a division: no done follows.
        @(negedge clk);
        bus.a = 32'h40C00000;
        bus.b = 32'h40000000;
        cur_exp.res = 32'h40400000;
        cur_exp.dbz = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle %0d: got running want finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
